// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem read per instruction, waits MEM_LAT
// cycles, holds the captured word for the consumer and handles redirects/halts.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        busy,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

   localparam logic [1:0] WaitInit = 2'(MEM_LAT - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic        flush_q, flush_d;
   logic        halt_pend_q, halt_pend_d;
   logic [31:0] inst_out_q, inst_out_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [15:0] count_q, count_d;
   logic        en_q, valid_q, busy_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      wcnt_d      = wcnt_q;
      flush_d     = flush_q;
      halt_pend_d = halt_pend_q;
      inst_out_d  = inst_out_q;
      inst_pc_d   = inst_pc_q;
      count_d     = count_q;
      unique case (state_q)
         StIdle: begin
            if (branch_taken) pc_d = branch_target;
            if (start) state_d = StIssue;
         end
         StIssue: begin
            wcnt_d  = WaitInit;
            state_d = StWait;
            if (halt) halt_pend_d = 1'b1;
            if (branch_taken) begin
               pc_d    = branch_target;
               flush_d = 1'b1;
            end
         end
         StWait: begin
            if (halt) halt_pend_d = 1'b1;
            if (branch_taken) begin
               pc_d    = branch_target;
               flush_d = 1'b1;
            end
            if (wcnt_q == 2'd0) begin
               flush_d = 1'b0;
               // A redirect seen at any point of this fetch discards the returned word.
               if (flush_q || branch_taken) begin
                  state_d = (halt_pend_q || halt) ? StIdle : StIssue;
               end else begin
                  inst_out_d = imem_rdata;
                  inst_pc_d  = pc_q;
                  state_d    = StDeliver;
               end
            end else begin
               wcnt_d = wcnt_q - 2'd1;
            end
         end
         StDeliver: begin
            if (halt) halt_pend_d = 1'b1;
            if (inst_ready) begin
               count_d = count_q + 16'd1;
               pc_d    = branch_taken ? branch_target : pc_q + PC_STEP;
               state_d = (halt_pend_q || halt) ? StIdle : StIssue;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StIdle) halt_pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         wcnt_q      <= 2'd0;
         flush_q     <= 1'b0;
         halt_pend_q <= 1'b0;
         inst_out_q  <= 32'd0;
         inst_pc_q   <= 32'd0;
         count_q     <= 16'd0;
         en_q        <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         wcnt_q      <= wcnt_d;
         flush_q     <= flush_d;
         halt_pend_q <= halt_pend_d;
         inst_out_q  <= inst_out_d;
         inst_pc_q   <= inst_pc_d;
         count_q     <= count_d;
         en_q        <= (state_d == StIssue);
         valid_q     <= (state_d == StDeliver);
         busy_q      <= (state_d != StIdle);
      end
   end

   assign imem_addr   = pc_q;
   assign imem_en     = en_q;
   assign inst_valid  = valid_q;
   assign inst_out    = inst_out_q;
   assign inst_pc     = inst_pc_q;
   assign busy        = busy_q;
   assign fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd1, sequential PC increment (word-indexed instruction memory).
REQ-003 SHALL have parameter MEM_LAT, default 1, legal 1..4, cycles from imem_en to valid imem_rdata.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  leave IDLE and begin fetching at current pc.
REQ-007 SHALL have port halt  input  1  request stop after the current instruction handoff.
REQ-008 SHALL have port branch_taken  input  1  redirect pc to branch_target.
REQ-009 SHALL have port branch_target  input  32  redirect address.
REQ-010 SHALL have port imem_addr  output  32  instruction memory address (equals pc).
REQ-011 SHALL have port imem_en  output  1  one-cycle read strobe to instruction memory.
REQ-012 SHALL have port imem_rdata  input  32  instruction word from memory.
REQ-013 SHALL have port inst_valid  output  1  inst_out/inst_pc valid for decode/Controller.
REQ-014 SHALL have port inst_ready  input  1  consumer accepts instruction this cycle.
REQ-015 SHALL have port inst_out  output  32  captured instruction; [31:22] feeds Controller opcode.
REQ-016 SHALL have port inst_pc  output  32  address inst_out was fetched from.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port fetch_count  output  16  number of completed handoffs, wraps at 2^16.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DELIVER.
REQ-020 IDLE: imem_en=0, inst_valid=0; start=1 -> ISSUE; branch_taken=1 loads pc<=branch_target and stays IDLE; branch_taken beats start same cycle (pc loaded, then ISSUE).
REQ-021 ISSUE: exactly one cycle, imem_en=1, imem_addr=pc, wait counter<=MEM_LAT-1, -> WAIT.
REQ-022 WAIT: lasts MEM_LAT cycles; on final WAIT cycle inst_out<=imem_rdata, inst_pc<=pc, -> DELIVER.
REQ-023 Latency: inst_valid SHALL rise MEM_LAT+1 cycles after the ISSUE cycle begins (2 cycles for MEM_LAT=1).
REQ-024 DELIVER: inst_valid=1; inst_out and inst_pc SHALL hold stable while inst_ready=0.
REQ-025 DELIVER with inst_ready=1: fetch_count+=1; pc<=branch_taken ? branch_target : pc+PC_STEP; -> IDLE if halt_pending or halt, else ISSUE.
REQ-026 pc+PC_STEP SHALL wrap modulo 2^32 (32'hFFFFFFFF+1 -> 0).
REQ-027 branch_taken in ISSUE or WAIT: pc<=branch_target, flush flag set; at WAIT end the fetched word is discarded (no DELIVER, no count), -> ISSUE at new pc; flush cleared.
REQ-028 branch_taken in DELIVER with inst_ready=0: ignored; redirect takes effect only with handoff.
REQ-029 halt in ISSUE/WAIT/DELIVER SHALL set sticky halt_pending, cleared on entering IDLE; halt during a flush exits to IDLE at WAIT end with pc=branch_target.
REQ-030 start while busy SHALL be ignored.
REQ-031 inst_valid, imem_en, busy SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-032 reset=1 at a rising edge SHALL force: state=IDLE, pc=RESET_PC, imem_en=0, inst_valid=0, inst_out=0, inst_pc=0, busy=0, fetch_count=0, halt_pending=0, flush=0.
REQ-033 reset SHALL override all other inputs, including mid-WAIT and mid-DELIVER; no handoff counted in the reset cycle.

Verification
REQ-034 Reset, start pulse, inst_ready=1, MEM_LAT=1, imem returns addr+100 -> imem_addr 0,1,2,...; inst_out 100,101,...; one handoff per 3 cycles; fetch_count increments each.
REQ-035 inst_ready held 0 for 5 cycles in DELIVER -> inst_valid stays 1, inst_out/inst_pc unchanged, no new imem_en, fetch_count unchanged.
REQ-036 branch_taken=1, branch_target=0x40 during WAIT of pc=3 -> word from 3 never valid; next imem_addr=0x40; first delivered inst_pc=0x40.
REQ-037 Branch with inst_ready in DELIVER at pc=7, target=0x10 -> next imem_addr=0x10, not 8; fetch_count+1.
REQ-038 pc forced via branch to 0xFFFFFFFF, sequential handoff -> next imem_addr=0x00000000.
REQ-039 halt pulse in WAIT, then reset asserted one cycle into a second run's WAIT -> first run ends in IDLE after one handoff (busy=0); reset yields pc=RESET_PC, inst_valid=0, fetch_count=0 next cycle.
